// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array operand feeder.
// Holds the feeder FSM state encoding and the default array geometry
// used by both the feeder and the systolic_array instantiation.
package sa_pkg;

  localparam int SA_N     = 8;
  localparam int SA_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_STREAM  = 2'd2,
    ST_READOUT = 2'd3
  } feed_state_e;

endpackage

// File: rtl/sa_operand_feeder_if.sv
// Load handshake and array-facing bus of the operand feeder.
// master: the operand source / array side; slave: the feeder itself.
interface sa_operand_feeder_if
  import sa_pkg::*;
#(
  parameter int N = SA_N
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic          load_valid;
  logic          load_ready;
  logic [N-1:0]  load_a;
  logic [N-1:0]  load_b;
  logic          load_last;
  logic          start;
  logic          busy;
  logic          acc_clear;
  logic [N-1:0]  in1;
  logic [N-1:0]  in2;
  logic          readout;
  logic [RW-1:0] row_idx;
  logic          done;

  modport master (
    output load_valid, load_a, load_b, load_last, start,
    input  load_ready, busy, acc_clear, in1, in2, readout, row_idx, done
  );

  modport slave (
    input  load_valid, load_a, load_b, load_last, start,
    output load_ready, busy, acc_clear, in1, in2, readout, row_idx, done
  );

endinterface

// File: rtl/sa_feed_buffer.sv
// DEPTH x 2N operand register file: one synchronous write port and one
// combinational read port. Contents are not reset; the parent's count
// decides which entries are valid.
module sa_feed_buffer #(
  parameter int N     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_a,
  input  logic [N-1:0]  wr_b,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_a,
  output logic [N-1:0]  rd_b
);

  logic [2*N-1:0] mem_q [DEPTH];

  // Store one {a,b} pair per accepted load.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= {wr_a, wr_b};
  end

  assign {rd_a, rd_b} = mem_q[rd_addr];

endmodule

// File: rtl/sa_operand_feeder.sv
// Operand feeder for the systolic_array outer-product accumulator.
// Buffers up to DEPTH (a,b) pairs, then per run: clears the array
// accumulators, streams the pairs one per cycle, and drives readout for
// N cycles with row_idx counting down. All outputs are registered.
// Optional build macro SA_FEED_REPLAY_EN keeps the buffer after a run so
// a later start replays the same pairs.
module sa_operand_feeder
  import sa_pkg::*;
#(
  parameter int N     = SA_N,
  parameter int DEPTH = SA_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  sa_operand_feeder_if.slave  bus
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;

  feed_state_e   state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [RW-1:0] row_q, row_d;
  logic          load_ready_q, load_ready_d;
  logic          busy_q, busy_d;
  logic          acc_clear_q, acc_clear_d;
  logic [N-1:0]  in1_q, in1_d;
  logic [N-1:0]  in2_q, in2_d;
  logic          readout_q, readout_d;
  logic          done_q, done_d;

  logic          wr_en;
  logic          trig;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  rd_a, rd_b;

  sa_feed_buffer #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_a    (bus.load_a),
    .wr_b    (bus.load_b),
    .rd_addr (rd_addr),
    .rd_a    (rd_a),
    .rd_b    (rd_b)
  );

  // Next state, buffer bookkeeping and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    row_d       = row_q;
    acc_clear_d = 1'b0;
    in1_d       = '0;
    in2_d       = '0;
    readout_d   = 1'b0;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    trig        = 1'b0;
    rd_addr     = rd_ptr_q[AW-1:0];

    case (state_q)
      ST_IDLE: begin
        wr_en = bus.load_valid && load_ready_q;
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
        end
        // A pair accepted alongside the trigger belongs to this run.
        trig = bus.start || (wr_en && bus.load_last);
        if (trig && (count_d != '0)) begin
          state_d     = ST_CLEAR;
          acc_clear_d = 1'b1;
          rd_ptr_d    = '0;
        end
      end
      ST_CLEAR: begin
        // Prefetch pair 0 so it is on in1/in2 in the first STREAM cycle.
        in1_d    = rd_a;
        in2_d    = rd_b;
        rd_ptr_d = rd_ptr_q + 1'b1;
        state_d  = ST_STREAM;
      end
      ST_STREAM: begin
        if (rd_ptr_q == count_q) begin
          state_d   = ST_READOUT;
          readout_d = 1'b1;
        end else begin
          in1_d    = rd_a;
          in2_d    = rd_b;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      ST_READOUT: begin
        if (row_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          row_d   = RW'(N - 1);
`ifdef SA_FEED_REPLAY_EN
          count_d  = count_q;
          wr_ptr_d = wr_ptr_q;
`else
          count_d  = '0;
          wr_ptr_d = '0;
`endif
        end else begin
          row_d     = row_q - 1'b1;
          readout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    load_ready_d = (state_d == ST_IDLE) && (count_d < (AW + 1)'(DEPTH));
    busy_d       = (state_d != ST_IDLE);
  end

  // State, pointers and output registers; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      row_q        <= RW'(N - 1);
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      acc_clear_q  <= 1'b0;
      in1_q        <= '0;
      in2_q        <= '0;
      readout_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      row_q        <= row_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      acc_clear_q  <= acc_clear_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      readout_q    <= readout_d;
      done_q       <= done_d;
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.busy       = busy_q;
  assign bus.acc_clear  = acc_clear_q;
  assign bus.in1        = in1_q;
  assign bus.in2        = in2_q;
  assign bus.readout    = readout_q;
  assign bus.row_idx    = row_q;
  assign bus.done       = done_q;

endmodule
